// File: rtl/ps2_key_fifo.sv
// ---------------------------------------------------------------------------
// ps2_key_fifo
//
// PS/2 keyboard receiver with key-event buffering. The raw keyboard lines are
// synchronised and level-filtered, 11-bit frames are deframed with odd-parity
// and stop-bit checks (plus an inactivity timeout), E0/F0 prefix bytes are
// folded into flags, and each resulting key event is queued in a show-ahead
// FIFO for the consumer.
//
// Parameters:
//   FILTER_LEN  consecutive identical samples needed to change a filtered level
//   TIMEOUT     clk cycles without a PS/2 clock fall before a frame is aborted
//   FIFO_DEPTH  event FIFO entries (power of two, >= 2)
//   CNT_W       width of fifo_count
//
// Ports:
//   clk, rstn          system clock, asynchronous active-low reset
//   PS2_CLK, PS2_DATA  raw keyboard lines (asynchronous to clk)
//   ready              consumer pops the head entry when valid && ready
//   clr_ovf            clears the sticky overflow flag
//   valid              FIFO not empty
//   key_code/key_ext/key_break  head entry {scan code, E0 seen, F0 seen}
//   fifo_count         FIFO occupancy, 0..FIFO_DEPTH
//   overflow           sticky: an event was dropped because the FIFO was full
//   parity_err         one-cycle pulse on a parity failure
//   frame_err          one-cycle pulse on a bad stop bit or a timeout
// ---------------------------------------------------------------------------
module ps2_key_fifo #(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 100000,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             PS2_CLK,
    input  logic             PS2_DATA,
    input  logic             ready,
    input  logic             clr_ovf,
    output logic             valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_break,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow,
    output logic             parity_err,
    output logic             frame_err
);

    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    // -----------------------------------------------------------------------
    // Input conditioning: bit 0 = keyboard clock, bit 1 = keyboard data
    // -----------------------------------------------------------------------
    logic [1:0] line_raw;
    logic [1:0] line_filt;

    assign line_raw = {PS2_DATA, PS2_CLK};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic          sync1_q, sync2_q;
            logic          filt_q, filt_d;
            logic [FW-1:0] cnt_q, cnt_d;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                    filt_q  <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= line_raw[gi];
                    sync2_q <= sync1_q;
                    filt_q  <= filt_d;
                    cnt_q   <= cnt_d;
                end
            end

            // cnt_q counts consecutive samples that disagree with the filtered
            // level; the level flips on the FILTER_LEN-th disagreeing sample.
            always_comb begin
                cnt_d  = '0;
                filt_d = filt_q;
                if (sync2_q != filt_q) begin
                    if (cnt_q == FW'(FILTER_LEN - 1)) begin
                        filt_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            assign line_filt[gi] = filt_q;
        end
    endgenerate

    logic clk_prev_q;
    logic fall;
    logic data_bit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= line_filt[0];
        end
    end

    // High in the first cycle the filtered clock reads 0.
    assign fall     = clk_prev_q & ~line_filt[0];
    assign data_bit = line_filt[1];

    // -----------------------------------------------------------------------
    // Deframer FSM with prefix folding
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          push;
    logic [9:0]    push_entry;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = '0;
        ext_d      = ext_q;
        brk_d      = brk_q;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        push       = 1'b0;
        push_entry = {ext_q, brk_q, shift_q};

        // Inactivity counter runs only inside a frame; any fall restarts it.
        if (state_q != S_IDLE && !fall) begin
            tmo_d = tmo_q + 1'b1;
        end

        if (state_q != S_IDLE && !fall && tmo_q == TW'(TIMEOUT - 1)) begin
            // Counter is about to reach TIMEOUT: abandon the frame.
            state_d = S_IDLE;
            tmo_d   = '0;
            ferr_d  = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A start bit of 1 is not a frame start.
                    if (fall && !data_bit) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    if (fall) begin
                        shift_d   = {data_bit, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (fall) begin
                        par_d   = data_bit;
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (fall) begin
                        state_d = S_IDLE;
                        if ((^{shift_q, par_q}) != 1'b1) begin
                            perr_d = 1'b1;
                            ext_d  = 1'b0;
                            brk_d  = 1'b0;
                        end else if (!data_bit) begin
                            ferr_d = 1'b1;
                            ext_d  = 1'b0;
                            brk_d  = 1'b0;
                        end else if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            push  = 1'b1;
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

    // -----------------------------------------------------------------------
    // Show-ahead event FIFO. The head is read asynchronously from the array
    // so a pushed entry is visible the cycle after the push.
    // -----------------------------------------------------------------------
    logic [9:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic             ovf_set;
    logic [9:0]       head;

    assign valid   = (count_q != '0);
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign do_pop  = valid & ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign ovf_set = push & full & ~do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        // Pointer widths equal log2(depth), so increments wrap on their own.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
        // A new overflow wins over a simultaneous clear.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr_q] <= push_entry;
        end
    end

    assign head = fifo_mem[rd_ptr_q];

    // Array contents are not reset, so the head outputs are masked when empty.
    assign key_code   = valid ? head[7:0] : 8'h00;
    assign key_break  = valid ? head[8]   : 1'b0;
    assign key_ext    = valid ? head[9]   : 1'b0;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_fifo
//
// Drives PS/2 frames into ps2_key_fifo. Every frame sent updates a
// behavioural model (prefix flags, expected-event queue, error tallies,
// overflow); a monitor process compares each entry the DUT hands over on
// valid && ready against the head of the expected queue.
// ---------------------------------------------------------------------------
module tb_ps2_key_fifo;

    localparam int FL    = 4;
    localparam int TMO   = 2000;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk      = 1'b0;
    logic          rstn     = 1'b0;
    logic          ps2_clk  = 1'b1;
    logic          ps2_data = 1'b1;
    logic          ready    = 1'b0;
    logic          clr_ovf  = 1'b0;
    logic          valid;
    logic [7:0]    key_code;
    logic          key_ext;
    logic          key_break;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          parity_err;
    logic          frame_err;

    ps2_key_fifo #(
        .FILTER_LEN (FL),
        .TIMEOUT    (TMO),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .PS2_CLK    (ps2_clk),
        .PS2_DATA   (ps2_data),
        .ready      (ready),
        .clr_ovf    (clr_ovf),
        .valid      (valid),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_break  (key_break),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] exp_q[$];
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;
    bit         m_ovf = 1'b0;
    int         exp_perr = 0;
    int         exp_ferr = 0;
    int         seen_perr = 0;
    int         seen_ferr = 0;
    bit         rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: sample mid-cycle, after the inputs for the next edge are set.
    always @(negedge clk) begin
        logic [9:0] e;
        #1;
        if (rstn) begin
            if (parity_err) seen_perr++;
            if (frame_err)  seen_ferr++;
            if (valid && ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pop: got ext=%0d brk=%0d code=%02h, required no entry",
                             key_ext, key_break, key_code);
                end else begin
                    e = exp_q.pop_front();
                    if ({key_ext, key_break, key_code} !== e) begin
                        n_err++;
                        $display("FAIL pop: got ext=%0d brk=%0d code=%02h, required ext=%0d brk=%0d code=%02h",
                                 key_ext, key_break, key_code, e[9], e[8], e[7:0]);
                    end else begin
                        $display("rx  ext=%0d brk=%0d code=%02h", key_ext, key_break, key_code);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Keyboard-side behaviour of one accepted/rejected frame.
    task automatic model_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit conc_pop);
        if (bad_par) begin
            exp_perr++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (bad_stop) begin
            exp_ferr++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() >= DEPTH && !conc_pop) m_ovf = 1'b1;
            else exp_q.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rand_ready) ready = ($urandom_range(0, 3) == 0);
        end
    endtask

    // One PS/2 bit: data set while the clock is high, then a low phase.
    // pop_here raises ready for exactly the edge that registers the push.
    task automatic drive_bit(input logic v, input int hp, input bit pop_here);
        ps2_data = v;
        wait_cyc(hp);
        ps2_clk = 1'b0;
        if (pop_here) begin
            repeat (2 + FL) @(posedge clk);
            @(negedge clk);
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
            wait_cyc(hp - 2);
        end else begin
            wait_cyc(hp);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int hp, input bit conc_pop);
        logic par;
        par = ~(^b) ^ bad_par;
        $display("tx  byte=%02h bad_par=%0d bad_stop=%0d hp=%0d", b, bad_par, bad_stop, hp);
        drive_bit(1'b0, hp, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i], hp, 1'b0);
        drive_bit(par, hp, 1'b0);
        model_byte(b, bad_par, bad_stop, conc_pop);
        drive_bit(~bad_stop, hp, conc_pop);
        ps2_data = 1'b1;
        wait_cyc(hp);
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, " fifo_count"}, 32'(fifo_count), 32'(exp_q.size()));
        check({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, " parity_err pulses"}, 32'(seen_perr), 32'(exp_perr));
        check({tag, " frame_err pulses"}, 32'(seen_ferr), 32'(exp_ferr));
    endtask

    task automatic check_head(input string tag, input logic [7:0] code, input logic ext,
                              input logic brk);
        check({tag, " valid"}, 32'(valid), 32'd1);
        check({tag, " key_code"}, 32'(key_code), 32'(code));
        check({tag, " key_ext"}, 32'(key_ext), 32'(ext));
        check({tag, " key_break"}, 32'(key_break), 32'(brk));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " valid"}, 32'(valid), 32'd0);
        check({tag, " key_code"}, 32'(key_code), 32'd0);
        check({tag, " key_ext"}, 32'(key_ext), 32'd0);
        check({tag, " key_break"}, 32'(key_break), 32'd0);
        check({tag, " fifo_count"}, 32'(fifo_count), 32'd0);
        check({tag, " overflow"}, 32'(overflow), 32'd0);
        check({tag, " parity_err"}, 32'(parity_err), 32'd0);
        check({tag, " frame_err"}, 32'(frame_err), 32'd0);
    endtask

    task automatic pop_n(input int n);
        @(negedge clk);
        ready = 1'b1;
        repeat (n) @(negedge clk);
        ready = 1'b0;
        settle();
    endtask

    initial begin
        logic [7:0] rb;
        int         r;
        int         e;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // Plain make code, then a single pop
        send_frame(8'h1C, 1'b0, 1'b0, 50, 1'b0);
        settle();
        check_head("make", 8'h1C, 1'b0, 1'b0);
        check("make fifo_count", 32'(fifo_count), 32'd1);
        pop_n(1);
        check("after pop valid", 32'(valid), 32'd0);
        check_model("after pop");

        // Prefix folding: F0 1C, E0 F0 75
        send_frame(8'hF0, 1'b0, 1'b0, 50, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 50, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0, 50, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 50, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0, 50, 1'b0);
        settle();
        check_head("prefix", 8'h1C, 1'b0, 1'b1);
        check("prefix fifo_count", 32'(fifo_count), 32'd2);
        pop_n(2);
        check_model("prefix drained");

        // Parity error, then F0 + bad stop, then a plain make
        send_frame(8'h1C, 1'b1, 1'b0, 50, 1'b0);
        settle();
        check_model("parity err");
        send_frame(8'hF0, 1'b0, 1'b0, 50, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 50, 1'b0);
        settle();
        check_model("stop err");
        send_frame(8'h1C, 1'b0, 1'b0, 50, 1'b0);
        settle();
        check_head("after stop err", 8'h1C, 1'b0, 1'b0);
        pop_n(1);

        // Timeout: start bit plus 5 data bits, then the clock goes quiet
        $display("tx  partial frame (timeout)");
        drive_bit(1'b0, 50, 1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'(i & 1), 50, 1'b0);
        exp_ferr++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        repeat (TMO + 10) @(negedge clk);
        check_model("timeout");
        send_frame(8'h29, 1'b0, 1'b0, 50, 1'b0);
        settle();
        check_head("after timeout", 8'h29, 1'b0, 1'b0);
        pop_n(1);

        // Fill past capacity with ready low
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 30, 1'b0);
        settle();
        check("full fifo_count", 32'(fifo_count), 32'(DEPTH));
        check("full overflow", 32'(overflow), 32'd1);
        check_model("full");
        pop_n(DEPTH);
        check_model("drained");
        @(negedge clk);
        clr_ovf = 1'b1;
        m_ovf   = 1'b0;
        @(negedge clk);
        clr_ovf = 1'b0;
        settle();
        check("clr_ovf overflow", 32'(overflow), 32'd0);

        // Refill, then push and pop together while full
        for (int i = 0; i < DEPTH; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b0, 20, 1'b0);
        settle();
        check_model("refill");
        send_frame(8'h19, 1'b0, 1'b0, 20, 1'b1);
        settle();
        check("push+pop fifo_count", 32'(fifo_count), 32'(DEPTH));
        check("push+pop overflow", 32'(overflow), 32'd0);
        check_model("push+pop");
        send_frame(8'h1A, 1'b0, 1'b0, 20, 1'b0);
        settle();
        check_model("overflow again");

        // Reset asserted mid-frame while the FIFO is full and overflowed
        drive_bit(1'b0, 30, 1'b0);
        drive_bit(1'b1, 30, 1'b0);
        ps2_data = 1'b0;
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(5);
        rstn = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_ovf = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("mid-frame reset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        settle();

        // Short low glitches on the clock line, with data held low
        ps2_data = 1'b0;
        repeat (5) begin
            @(negedge clk);
            ps2_clk = 1'b0;
            repeat (2) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
        ps2_data = 1'b1;
        settle();
        send_frame(8'h1C, 1'b0, 1'b0, 50, 1'b0);
        settle();
        check_head("after glitch", 8'h1C, 1'b0, 1'b0);
        check_model("after glitch");
        pop_n(1);

        // Randomised traffic with a randomly toggling consumer
        rand_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            r  = $urandom_range(0, 5);
            rb = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
            e  = $urandom_range(0, 9);
            send_frame(rb, e == 0, e == 1, $urandom_range(12, 40), 1'b0);
        end
        rand_ready = 1'b0;
        pop_n(DEPTH + 4);
        check("random leftover entries", 32'(exp_q.size()), 32'd0);
        check("random valid", 32'(valid), 32'd0);
        check_model("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
